bullet_ctrl: RTL

- Owns the kid's bullet pool: up to 4 bullets, each with a position and a facing direction.
- Spawns a bullet on a shoot press and advances active bullets once per frame. Retires bullets at the screen edge.
- Drives the packed `bullet_x`/`bullet_y` buses consumed by the save-point button stage, and the bullet pixel overlay consumed by the VGA mixer.

---
 rtl/game_pkg.sv | 20 ++
 rtl/bullet_slot.sv | 88 ++++++++
 rtl/bullet_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants: screen geometry, invalid-coordinate marker, pool size, direction encoding.
// Also holds the box-span test used by the pixel overlays.
package game_pkg;

    localparam int          SCREEN_W      = 640;
    localparam int          SCREEN_H      = 480;
    localparam logic [9:0]  INVALID_COORD = 10'h3FF;
    localparam int          NUM_BULLETS   = 4;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    // Half-open span test done in 11 bits so lo+len never wraps.
    function automatic logic in_span(input logic [9:0] p, input logic [9:0] lo, input logic [10:0] len);
        return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < ({1'b0, lo} + len));
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: active/dir/x/y state, per-frame move with edge retire, spawn load port, pixel hit.
// State updates on the tick cycle; hit_o is combinational; no backpressure.
module bullet_slot
    import game_pkg::*;
#(
    parameter int SPEED    = 8,
    parameter int BULLET_W = 4,
    parameter int BULLET_H = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_i,
    input  logic       load_i,
    input  logic [9:0] load_x_i,
    input  logic [9:0] load_y_i,
    input  logic       load_dir_i,
    input  logic [9:0] col_i,
    input  logic [9:0] row_i,
    output logic       active_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       hit_o
);

    localparam logic [10:0] RETIRE_X = 11'(SCREEN_W - BULLET_W);

    logic        active_q, active_d;
    dir_e        dir_q, dir_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [10:0] x_fwd;
    logic [9:0]  x_back;

    assign x_fwd  = {1'b0, x_q} + 11'(SPEED);
    assign x_back = x_q - 10'(SPEED);

    always_comb begin
        active_d = active_q;
        dir_d    = dir_q;
        x_d      = x_q;
        y_d      = y_q;
        if (tick_i && active_q) begin
            if (dir_q == DIR_RIGHT) begin
                if (x_fwd >= RETIRE_X) begin
                    active_d = 1'b0;
                    x_d      = INVALID_COORD;
                    y_d      = INVALID_COORD;
                end else begin
                    x_d = x_fwd[9:0];
                end
            end else begin
                // Left mover retires before it could underflow past column 0.
                if ({1'b0, x_q} < 11'(SPEED)) begin
                    active_d = 1'b0;
                    x_d      = INVALID_COORD;
                    y_d      = INVALID_COORD;
                end else begin
                    x_d = x_back;
                end
            end
        end else if (load_i) begin
            active_d = 1'b1;
            dir_d    = dir_e'(load_dir_i);
            x_d      = load_x_i;
            y_d      = load_y_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            dir_q    <= DIR_RIGHT;
            x_q      <= INVALID_COORD;
            y_q      <= INVALID_COORD;
        end else begin
            active_q <= active_d;
            dir_q    <= dir_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign active_o = active_q;
    assign x_o      = active_q ? x_q : INVALID_COORD;
    assign y_o      = active_q ? y_q : INVALID_COORD;
    assign hit_o    = active_q && in_span(col_i, x_q, 11'(BULLET_W)) && in_span(row_i, y_q, 11'(BULLET_H));

endmodule

// File: rtl/bullet_ctrl.sv
// Bullet pool: shoot capture, spawn cooldown, lowest-free-slot spawn, per-frame advance, pixel overlay.
// Spawn/move on frame_tick (visible 1 clk later), overlay 0 latency; no backpressure, dropped shots are lost. Option: BULLET_AUTOFIRE_EN.
module bullet_ctrl
    import game_pkg::*;
#(
    parameter int          NUM_BULLETS = game_pkg::NUM_BULLETS,
    parameter int          SPEED       = 8,
    parameter int          COOLDOWN    = 6,
    parameter int          BULLET_W    = 4,
    parameter int          BULLET_H    = 4,
    parameter int          SPAWN_DX    = 16,
    parameter int          SPAWN_DY    = 12,
    parameter logic [11:0] BULLET_RGB  = 12'h000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_tick,
    input  logic                      shoot,
    input  logic [9:0]                kid_x,
    input  logic [9:0]                kid_y,
    input  logic                      kid_dir,
    input  logic [9:0]                col,
    input  logic [9:0]                row,
    output logic [NUM_BULLETS*10-1:0] bullet_x,
    output logic [NUM_BULLETS*10-1:0] bullet_y,
    output logic [NUM_BULLETS-1:0]    active,
    output logic                      is_bullet,
    output logic [11:0]               bullet_rgb
);

    localparam int          CW          = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [10:0] SPAWN_X_MAX = 11'(SCREEN_W - BULLET_W);

    logic                   shoot_d_q, shoot_d_d;
    logic                   pending_q, pending_d;
    logic [CW-1:0]          cooldown_q, cooldown_d;
    logic                   shot_req;
    logic                   shot_now;
    logic [NUM_BULLETS-1:0] free_oh;
    logic                   free_vld;
    logic [NUM_BULLETS-1:0] load_vec;
    logic [NUM_BULLETS-1:0] hit;
    dir_e                   spawn_dir;
    logic [10:0]            spawn_x_wide;
    logic [9:0]             spawn_y;
    logic                   spawn_x_ok;
    logic                   spawn_go;

`ifdef BULLET_AUTOFIRE_EN
    assign shot_req = shoot;
`else
    assign shot_req = shoot & ~shoot_d_q;
`endif

    // A request arriving on the tick cycle itself is honoured on that tick.
    assign shot_now = pending_q | shot_req;

    assign spawn_dir    = dir_e'(kid_dir);
    assign spawn_x_wide = (spawn_dir == DIR_LEFT) ? ({1'b0, kid_x} - 11'(BULLET_W))
                                                  : ({1'b0, kid_x} + 11'(SPAWN_DX));
    // Underflow on a left spawn wraps high in 11 bits, so one upper bound covers both sides.
    assign spawn_x_ok   = (spawn_x_wide <= SPAWN_X_MAX);
    assign spawn_y      = kid_y + 10'(SPAWN_DY);

    always_comb begin
        free_oh  = '0;
        free_vld = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!active[i] && !free_vld) begin
                free_oh[i] = 1'b1;
                free_vld   = 1'b1;
            end
        end
    end

    assign spawn_go = frame_tick && shot_now && (cooldown_q == '0) && free_vld && spawn_x_ok;
    assign load_vec = spawn_go ? free_oh : '0;

    always_comb begin
        shoot_d_d  = shoot;
        pending_d  = frame_tick ? 1'b0 : shot_now;
        cooldown_d = cooldown_q;
        if (frame_tick) begin
            if (spawn_go) begin
                cooldown_d = CW'(COOLDOWN);
            end else if (cooldown_q != '0) begin
                cooldown_d = cooldown_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shoot_d_q  <= 1'b0;
            pending_q  <= 1'b0;
            cooldown_q <= '0;
        end else begin
            shoot_d_q  <= shoot_d_d;
            pending_q  <= pending_d;
            cooldown_q <= cooldown_d;
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        bullet_slot #(
            .SPEED    (SPEED),
            .BULLET_W (BULLET_W),
            .BULLET_H (BULLET_H)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .tick_i     (frame_tick),
            .load_i     (load_vec[g]),
            .load_x_i   (spawn_x_wide[9:0]),
            .load_y_i   (spawn_y),
            .load_dir_i (kid_dir),
            .col_i      (col),
            .row_i      (row),
            .active_o   (active[g]),
            .x_o        (bullet_x[g*10 +: 10]),
            .y_o        (bullet_y[g*10 +: 10]),
            .hit_o      (hit[g])
        );
    end

    assign is_bullet  = |hit;
    assign bullet_rgb = BULLET_RGB;

endmodule
